// File: rtl/aes_pkg.sv
// Shared AES definitions: AES-256 sizing constants, key/round-key word types,
// the key-scheduler FSM state encoding and the round-constant helper.
package aes_pkg;

   localparam int unsigned AES256_NR = 14;
   localparam int unsigned AES256_NK = 8;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned RK_W      = 128;
   localparam int unsigned KEY_W     = 256;
   localparam int unsigned IDX_W     = 4;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [RK_W-1:0]   round_key_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_READY  = 2'd2
   } state_e;

   // Round constant for an even round-key index rnd: 01 << (rnd/2 - 1).
   function automatic logic [7:0] rcon(input logic [IDX_W-1:0] rnd);
      logic [IDX_W-1:0] sh;
      sh = (rnd >> 1) - IDX_W'(1);
      return 8'h01 << sh;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Ports: byte_i (8-bit input byte), sbox_c (8-bit substituted byte).
// The multiplicative inverse is x^254 in GF(2^8), followed by the affine map.
module aes_sbox (
   input  logic [7:0] byte_i,
   output logic [7:0] sbox_c
);

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] inv;
   logic [7:0] sq;

   // x^254 = product of x^(2^k) for k = 1..7; maps 0 to 0 as required.
   always_comb begin
      inv = 8'h01;
      sq  = byte_i;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      sbox_c = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/aes256_key_scheduler.sv
// Iterative AES-256 key expansion: accepts a 256-bit key, writes one 128-bit
// round key per cycle into a 15-entry flop store, and serves keys by index.
// Ports: clk_i, rst_ni (async active-low); key_valid_i/key_ready_o/key_i key
// handshake; clear_i synchronous wipe; keys_ready_o, done_o, busy_o status;
// rk_idx_i read index and rk_o registered round key.
module aes256_key_scheduler
   import aes_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             key_valid_i,
   output logic             key_ready_o,
   input  logic [KEY_W-1:0] key_i,
   input  logic             clear_i,
   output logic             keys_ready_o,
   output logic             done_o,
   output logic             busy_o,
   input  logic [IDX_W-1:0] rk_idx_i,
   output round_key_t       rk_o
);

   localparam int unsigned NUM_RK = AES256_NR + 1;

   state_e           state_q, state_d;
   round_key_t       store_q [NUM_RK];
   round_key_t       store_d [NUM_RK];
   logic [KEY_W-1:0] window_q, window_d;
   logic [IDX_W-1:0] rnd_q, rnd_d;
   logic             keys_ready_q, keys_ready_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   round_key_t       rk_q, rk_d;

   logic       accept;
   word_t      b3, sub_in, sub_out, t;
   word_t      n0, n1, n2, n3;
   round_key_t n_rk;
   logic       last_rnd;

   // Ready is decoded straight from state so it is high throughout reset.
   assign key_ready_o = (state_q != ST_EXPAND);
   assign accept      = key_valid_i && key_ready_o && !clear_i;
   assign last_rnd    = (rnd_q == IDX_W'(AES256_NR));

   // Round function: odd rounds use SubWord only, even rounds add RotWord+rcon.
   assign b3     = window_q[WORD_W-1:0];
   assign sub_in = rnd_q[0] ? b3 : {b3[23:0], b3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .byte_i (sub_in[8*g +: 8]),
         .sbox_c (sub_out[8*g +: 8])
      );
   end

   assign t    = rnd_q[0] ? sub_out : (sub_out ^ {rcon(rnd_q), 24'h0});
   assign n0   = window_q[255:224] ^ t;
   assign n1   = window_q[223:192] ^ n0;
   assign n2   = window_q[191:160] ^ n1;
   assign n3   = window_q[159:128] ^ n2;
   assign n_rk = {n0, n1, n2, n3};

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; clear overrides everything.
   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_READY: if (key_valid_i) state_d = ST_EXPAND;
            ST_EXPAND:         if (last_rnd)    state_d = ST_READY;
            default:           state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath and status next values.
   always_comb begin
      store_d      = store_q;
      window_d     = window_q;
      rnd_d        = rnd_q;
      keys_ready_d = keys_ready_q;
      done_d       = 1'b0;
      busy_d       = busy_q;
      rk_d         = '0;

      for (int i = 0; i < NUM_RK; i++) begin
         if (rk_idx_i == IDX_W'(i)) rk_d = store_q[i];
      end

      if (clear_i) begin
         for (int i = 0; i < NUM_RK; i++) store_d[i] = '0;
         window_d     = '0;
         rnd_d        = '0;
         keys_ready_d = 1'b0;
         busy_d       = 1'b0;
         rk_d         = '0;
      end else if (accept) begin
         store_d[0]   = key_i[255:128];
         store_d[1]   = key_i[127:0];
         window_d     = key_i;
         rnd_d        = IDX_W'(2);
         keys_ready_d = 1'b0;
         busy_d       = 1'b1;
      end else if (state_q == ST_EXPAND) begin
         for (int i = 0; i < NUM_RK; i++) begin
            if (rnd_q == IDX_W'(i)) store_d[i] = n_rk;
         end
         window_d = {window_q[127:0], n_rk};
         rnd_d    = rnd_q + IDX_W'(1);
         if (last_rnd) begin
            keys_ready_d = 1'b1;
            done_d       = 1'b1;
            busy_d       = 1'b0;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_RK; i++) store_q[i] <= '0;
         window_q     <= '0;
         rnd_q        <= '0;
         keys_ready_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         rk_q         <= '0;
      end else begin
         for (int i = 0; i < NUM_RK; i++) store_q[i] <= store_d[i];
         window_q     <= window_d;
         rnd_q        <= rnd_d;
         keys_ready_q <= keys_ready_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         rk_q         <= rk_d;
      end
   end

   assign keys_ready_o = keys_ready_q;
   assign done_o       = done_q;
   assign busy_o       = busy_q;
   assign rk_o         = rk_q;

endmodule

// File: tb/tb_aes256_key_scheduler.sv
// Self-checking bench for aes256_key_scheduler: a FIPS-197 style key
// expansion model predicts the store and status outputs every cycle.
module tb_aes256_key_scheduler;

   localparam logic [255:0] KEY_C3 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEY_A3 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         key_valid_i;
   logic         key_ready_o;
   logic [255:0] key_i;
   logic         clear_i;
   logic         keys_ready_o;
   logic         done_o;
   logic         busy_o;
   logic [3:0]   rk_idx_i;
   logic [127:0] rk_o;

   always #5 clk_i = ~clk_i;

   aes256_key_scheduler dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .key_valid_i  (key_valid_i),
      .key_ready_o  (key_ready_o),
      .key_i        (key_i),
      .clear_i      (clear_i),
      .keys_ready_o (keys_ready_o),
      .done_o       (done_o),
      .busy_o       (busy_o),
      .rk_idx_i     (rk_idx_i),
      .rk_o         (rk_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   logic [31:0]  m_w [60];
   logic [127:0] m_store [15];
   logic         m_exp;
   int           m_k;
   logic         m_kr, m_done, m_busy;
   logic [127:0] m_rk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box from the definition: inverse by exhaustive search, then affine map.
   function automatic logic [7:0] m_sbox(input logic [7:0] x);
      logic [7:0] inv = 8'h00;
      logic [7:0] r;
      if (x != 8'h00)
         for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      r = 8'h63;
      for (int s = 0; s < 5; s++) r = r ^ ((inv << s) | (inv >> (8 - s)));
      return r;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
   endfunction

   task automatic expand(input logic [255:0] key);
      logic [31:0] temp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 8; i++) m_w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         temp = m_w[i-1];
         if (i % 8 == 0) begin
            temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
            rc   = xt(rc);
         end else if (i % 8 == 4) begin
            temp = sub_word(temp);
         end
         m_w[i] = m_w[i-8] ^ temp;
      end
   endtask

   function automatic logic [127:0] m_rkey(input int k);
      return {m_w[4*k], m_w[4*k+1], m_w[4*k+2], m_w[4*k+3]};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 15; i++) m_store[i] = '0;
      m_exp = 1'b0; m_k = 0; m_kr = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_rk = '0;
   endtask

   // Model reaction to one rising edge, from the inputs present at that edge.
   task automatic model_edge();
      logic [127:0] rd = '0;
      if (rk_idx_i <= 4'd14) rd = m_store[rk_idx_i];
      m_done = 1'b0;
      m_rk   = rd;
      if (clear_i) begin
         m_reset();
      end else if (key_valid_i && !m_exp) begin
         expand(key_i);
         m_store[0] = key_i[255:128];
         m_store[1] = key_i[127:0];
         m_exp = 1'b1; m_k = 2; m_kr = 1'b0; m_busy = 1'b1;
      end else if (m_exp) begin
         m_store[m_k] = m_rkey(m_k);
         if (m_k == 14) begin
            m_exp = 1'b0; m_kr = 1'b1; m_done = 1'b1; m_busy = 1'b0;
         end
         m_k++;
      end
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("key_ready_o",  128'(key_ready_o),  128'(!m_exp));
      chk("keys_ready_o", 128'(keys_ready_o), 128'(m_kr));
      chk("done_o",       128'(done_o),       128'(m_done));
      chk("busy_o",       128'(busy_o),       128'(m_busy));
      chk("rk_o",         rk_o,               m_rk);
   endtask

   task automatic step();
      @(posedge clk_i);
      model_edge();
      #1;
      compare_all();
   endtask

   function automatic logic [255:0] rand256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic read_check(input logic [3:0] idx, input string name, input logic [127:0] exp);
      rk_idx_i = idx;
      step();
      chk(name, rk_o, exp);
   endtask

   int busy_cnt, done_cnt, rise_at;

   initial begin
      rst_ni = 1'b0; key_valid_i = 1'b1; key_i = KEY_C3; clear_i = 1'b0; rk_idx_i = 4'd0;
      m_reset();

      // Pin the model on known vectors before it drives any expectation.
      expand(KEY_C3);
      chk("model_c3_rk2",  m_rkey(2),  128'ha573c29fa176c498a97fce93a572c09c);
      chk("model_c3_rk14", m_rkey(14), 128'h24fc79ccbf0979e9371ac23c6d68de36);
      expand(KEY_A3);
      chk("model_a3_rk14", m_rkey(14), 128'hfe4890d1e6188d0b046df344706c631e);

      #2;
      compare_all();
      chk("reset_key_ready", 128'(key_ready_o), 128'd1);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Key held from reset: accepted on the first edge; a second key offered
      // during expansion must be ignored.
      busy_cnt = 0; done_cnt = 0;
      step();
      busy_cnt += int'(busy_o);
      key_i = rand256();
      for (int c = 0; c < 16; c++) begin
         if (c == 5) key_valid_i = 1'b0;
         rk_idx_i = 4'($urandom_range(0, 15));
         step();
         busy_cnt += int'(busy_o);
         done_cnt += int'(done_o);
      end
      chk("busy_cycles", 128'(busy_cnt), 128'd13);
      chk("done_pulses", 128'(done_cnt), 128'd1);
      read_check(4'd0,  "c3_rk0",  128'h000102030405060708090a0b0c0d0e0f);
      read_check(4'd2,  "c3_rk2",  128'ha573c29fa176c498a97fce93a572c09c);
      read_check(4'd3,  "c3_rk3",  128'h1651a8cd0244beda1a5da4c10640bade);
      read_check(4'd14, "c3_rk14", 128'h24fc79ccbf0979e9371ac23c6d68de36);

      // Re-key while READY.
      key_i = KEY_A3; key_valid_i = 1'b1;
      step();
      key_valid_i = 1'b0;
      chk("rekey_drop", 128'(keys_ready_o), 128'd0);
      rise_at = 0;
      for (int c = 1; c <= 14; c++) begin
         rk_idx_i = 4'($urandom_range(0, 15));
         step();
         if (keys_ready_o && rise_at == 0) rise_at = c;
      end
      chk("rekey_rise", 128'(rise_at), 128'd13);
      read_check(4'd14, "a3_rk14", 128'hfe4890d1e6188d0b046df344706c631e);

      // Random keys with random reads during and after expansion.
      for (int n = 0; n < 3; n++) begin
         key_i = rand256(); key_valid_i = 1'b1;
         step();
         key_valid_i = 1'b0;
         for (int c = 0; c < 15; c++) begin
            rk_idx_i = 4'($urandom_range(0, 15));
            step();
         end
         for (int i = 0; i < 16; i++) begin
            rk_idx_i = 4'(i);
            step();
         end
      end

      // Clear in the fifth EXPAND cycle, together with a key offer.
      key_i = rand256(); key_valid_i = 1'b1;
      step();
      key_valid_i = 1'b0;
      for (int c = 0; c < 4; c++) step();
      clear_i = 1'b1; key_valid_i = 1'b1;
      step();
      chk("clear_idle", 128'(key_ready_o), 128'd1);
      step();
      chk("clear_no_accept", 128'(busy_o), 128'd0);
      clear_i = 1'b0; key_valid_i = 1'b0;
      for (int i = 0; i < 15; i++) read_check(4'(i), "clear_rk_zero", 128'h0);

      // Asynchronous reset in the middle of an expansion.
      key_i = rand256(); key_valid_i = 1'b1;
      step();
      key_valid_i = 1'b0;
      for (int c = 0; c < 6; c++) step();
      #2;
      rst_ni = 1'b0;
      #1;
      m_reset();
      compare_all();
      @(negedge clk_i);
      rst_ni = 1'b1;
      key_i = rand256(); key_valid_i = 1'b1;
      step();
      key_valid_i = 1'b0;
      for (int c = 0; c < 13; c++) step();
      for (int i = 0; i < 15; i++) begin
         rk_idx_i = 4'(i);
         step();
      end

      read_check(4'd15, "idx15_zero", 128'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes256_key_scheduler.md
# aes256_key_scheduler

Iterative, registered AES-256 key expansion controller. It accepts a 256-bit master key over a valid/ready handshake and generates one 128-bit round key per cycle into a 15-entry round-key store. It then serves round keys by index to the iterative cipher round engine. It replaces the fully combinational expansion wherever the 60-word LUT cone is too costly, trading 13 cycles of latency for roughly 4 S-boxes of logic.

## Interface
- NR, 14: number of cipher rounds; the store holds NR+1 round keys. Fixed for AES-256.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- key_valid_i  in  1  master key offered.
- key_ready_o  out  1  scheduler can accept a key.
- key_i  in  256  master key; word 0 is bits [255:224].
- clear_i  in  1  synchronous wipe of all key material.
- keys_ready_o  out  1  all 15 round keys are valid in the store.
- done_o  out  1  one-cycle pulse when expansion completes.
- busy_o  out  1  expansion in progress.
- rk_idx_i  in  4  round-key read index, 0..14.
- rk_o  out  128  registered round key for rk_idx_i.

## Operation
- FSM states:
  - IDLE: reset state.
  - EXPAND: expansion running.
  - READY: all keys valid.
- key_ready_o = (state != EXPAND); it is decoded from state and is 1 during reset.
- Key accept happens when key_valid_i && key_ready_o, in IDLE or READY:
  - store[0] <= key_i[255:128]; store[1] <= key_i[127:0].
  - window <= key_i; rnd <= 2; state <= EXPAND.
  - keys_ready_o <= 0.
- Each EXPAND cycle computes round key rnd from window {A = 4 older words, B = 4 newer words}:
  - t = SubWord(RotWord(B[3])) ^ {rcon, 24'h0} when rnd is even, with rcon = 8'h01 << (rnd/2 − 1), giving 01..40.
  - t = SubWord(B[3]) when rnd is odd.
  - N0 = A0^t, N1 = A1^N0, N2 = A2^N1, N3 = A3^N2.
  - store[rnd] <= N; window <= {B, N}; rnd <= rnd+1.
- When rnd == 14 is written: state <= READY, keys_ready_o <= 1, done_o <= 1 for one cycle, busy_o <= 0.
- busy_o = 1 exactly while in EXPAND.
- Read port:
  - rk_o <= (rk_idx_i <= 14) ? store[rk_idx_i] : 128'h0, updated every cycle in all states.
  - Reads during EXPAND return the current store contents, which may be stale or partially new. Consumers must gate on keys_ready_o.
- clear_i:
  - Has priority over key accept and over EXPAND.
  - Next cycle: store, window and rk_o are zeroed; rnd <= 0; state <= IDLE; keys_ready_o, done_o and busy_o are 0.
- Re-key in READY is allowed. keys_ready_o drops the cycle after accept, and store[2..14] keeps the old values until each is overwritten.
- key_valid_i during EXPAND is ignored because key_ready_o = 0. No queuing.

## Timing
- Reset values:
  - state IDLE, key_ready_o 1.
  - keys_ready_o, done_o, busy_o 0; rk_o 0.
  - store and window all-zero; rnd 0.
- Latency: accept edge T → store[k] is written at edge T+(k−1) for k = 2..14. keys_ready_o and done_o are high after edge T+13.
- Read latency is 1 cycle: rk_idx_i sampled at edge T appears on rk_o after edge T.
- Reset asserted mid-expansion aborts immediately to reset values. There is no partial-key visibility afterwards.
- clear_i and key_valid_i in the same cycle: clear wins and the key is not accepted.
- Critical path: 4 S-boxes plus a 4-word XOR chain. No cross-round combinational cone.

## Structure
- Shared package aes_pkg holds:
  - AES256_NR = 14 and AES256_NK = 8.
  - The rcon function.
  - The round_key_t (128-bit) and word_t (32-bit) typedefs.
  - The FSM state enum.
- One sub-module, aes_sbox: an 8-bit combinational forward S-box, instantiated 4× for SubWord. The same module is shared with the cipher datapath.
- The store is 15×128 flops, not RAM, because of the single-cycle clear requirement.

## Test plan
- FIPS-197 C.3 key 000102…1e1f:
  - After done_o, rk_idx 0 → 000102030405060708090a0b0c0d0e0f.
  - rk_idx 2 → a573c29fa176c498a97fce93a572c09c.
  - rk_idx 3 → 1651a8cd0244beda1a5da4c10640bade.
  - rk_idx 14 → 24fc79ccbf0979e9371ac23c6d68de36.
- Handshake and latency:
  - key_valid_i held high from reset → accept on the first edge.
  - busy_o high for exactly 13 cycles; done_o is a single pulse.
  - key_ready_o is low throughout EXPAND, and a second key offered during EXPAND is ignored.
- Re-key in READY with FIPS-197 key 603deb10…0914dff4 → keys_ready_o drops next cycle, rises 13 cycles later, and rk 14 matches the FIPS-197 vector for that key.
- clear_i asserted at EXPAND cycle 5 → next cycle state IDLE, and reads of rk 0..14 all return zero. clear_i together with key_valid_i → no accept.
- rst_ni pulsed low mid-EXPAND → all outputs return to reset values asynchronously, then a new key expands correctly.
- rk_idx_i = 15 → rk_o = 0 one cycle later.
